// File: rtl/mult_writeback_if.sv
// Handshake bundle between the last multiplier stage, the writeback queue and the CDB arbiter.
interface mult_wb_if #(
  parameter int XLEN   = 32,
  parameter int PROD_W = 64,
  parameter int PREG_W = 6,
  parameter int BM_W   = 4
);
  logic              in_valid;
  logic [PROD_W-1:0] in_prod;
  logic [PREG_W-1:0] in_dest;
  logic [BM_W-1:0]   in_bm;
  logic [1:0]        in_func;
  logic              in_ready;
  logic [BM_W-1:0]   b_mm_resolve;
  logic              b_mm_mispred;
  logic              out_valid;
  logic [XLEN-1:0]   out_result;
  logic [PREG_W-1:0] out_dest;
  logic [BM_W-1:0]   out_bm;
  logic              cdb_grant;
  logic [1:0]        occupancy;

  modport slave (
    input  in_valid, in_prod, in_dest, in_bm, in_func, b_mm_resolve, b_mm_mispred, cdb_grant,
    output in_ready, out_valid, out_result, out_dest, out_bm, occupancy
  );

  modport master (
    output in_valid, in_prod, in_dest, in_bm, in_func, b_mm_resolve, b_mm_mispred, cdb_grant,
    input  in_ready, out_valid, out_result, out_dest, out_bm, occupancy
  );
endinterface

// File: rtl/mult_writeback.sv
// Multiplier drain stage: 2-entry in-order result queue feeding the CDB, with branch-mask squash.
// Optional MULT_WB_BYPASS_EN presents an incoming packet combinationally when the queue is empty.
module mult_writeback #(
  parameter int DEPTH  = 2,
  parameter int XLEN   = 32,
  parameter int PROD_W = 64,
  parameter int PREG_W = 6,
  parameter int BM_W   = 4
) (
  input  logic     clock,
  input  logic     reset_n,
  mult_wb_if.slave bus
);
  localparam logic [1:0] DEPTH_C = 2'(DEPTH);

  logic [1:0]             vld;
  logic [1:0][XLEN-1:0]   res;
  logic [1:0][PREG_W-1:0] dst;
  logic [1:0][BM_W-1:0]   bm;

  logic [1:0]             n_vld;
  logic [1:0][XLEN-1:0]   n_res;
  logic [1:0][PREG_W-1:0] n_dst;
  logic [1:0][BM_W-1:0]   n_bm;

  logic [1:0]      sq;
  logic            in_sq, q_valid, byp, pop, acc, wr, keep0, keep1;
  logic [1:0]      occ;
  logic [XLEN-1:0] in_res;
  logic [BM_W-1:0] in_bm_clr;

  always_comb begin
    for (int i = 0; i < 2; i++)
      sq[i] = bus.b_mm_mispred && |(bm[i] & bus.b_mm_resolve);
  end

  assign in_sq     = bus.b_mm_mispred && |(bus.in_bm & bus.b_mm_resolve);
  assign in_res    = (bus.in_func == 2'd0) ? bus.in_prod[XLEN-1:0]
                                           : bus.in_prod[PROD_W-1:PROD_W-XLEN];
  assign in_bm_clr = bus.in_bm & ~bus.b_mm_resolve;
  assign occ       = {1'b0, vld[0]} + {1'b0, vld[1]};
  assign q_valid   = vld[0] && !sq[0];

`ifdef MULT_WB_BYPASS_EN
  assign byp = (occ == 2'd0) && bus.in_valid && !in_sq;
`else
  assign byp = 1'b0;
`endif

  // A killed head never requests, so it can never be popped.
  assign bus.out_valid = q_valid || byp;
  assign pop           = q_valid && bus.cdb_grant;
  assign bus.in_ready  = (occ < DEPTH_C) || (bus.out_valid && bus.cdb_grant);
  assign acc           = bus.in_valid && bus.in_ready;
  // Dropped (mispredicted) packets and bypassed-and-granted packets complete the handshake without a write.
  assign wr            = acc && !in_sq && !(byp && bus.cdb_grant);
  assign bus.occupancy = occ;

  always_comb begin
    bus.out_result = '0;
    bus.out_dest   = '0;
    bus.out_bm     = '0;
    if (byp) begin
      bus.out_result = in_res;
      bus.out_dest   = bus.in_dest;
      bus.out_bm     = in_bm_clr;
    end else if (occ != 2'd0) begin
      bus.out_result = res[0];
      bus.out_dest   = dst[0];
      bus.out_bm     = bm[0];
    end
  end

  assign keep0 = vld[0] && !sq[0] && !pop;
  assign keep1 = vld[1] && !sq[1];

  // Survivors compact toward the head; the new packet lands behind them.
  always_comb begin
    n_vld = '0;
    n_res = res;
    n_dst = dst;
    for (int i = 0; i < 2; i++) n_bm[i] = bm[i] & ~bus.b_mm_resolve;
    if (keep0) begin
      n_vld[0] = 1'b1;
      if (keep1) begin
        n_vld[1] = 1'b1;
      end else if (wr) begin
        n_vld[1] = 1'b1;
        n_res[1] = in_res;
        n_dst[1] = bus.in_dest;
        n_bm[1]  = in_bm_clr;
      end
    end else if (keep1) begin
      n_vld[0] = 1'b1;
      n_res[0] = res[1];
      n_dst[0] = dst[1];
      n_bm[0]  = bm[1] & ~bus.b_mm_resolve;
      if (wr) begin
        n_vld[1] = 1'b1;
        n_res[1] = in_res;
        n_dst[1] = bus.in_dest;
        n_bm[1]  = in_bm_clr;
      end
    end else if (wr) begin
      n_vld[0] = 1'b1;
      n_res[0] = in_res;
      n_dst[0] = bus.in_dest;
      n_bm[0]  = in_bm_clr;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      vld <= '0;
      res <= '0;
      dst <= '0;
      bm  <= '0;
    end else begin
      vld <= n_vld;
      res <= n_res;
      dst <= n_dst;
      bm  <= n_bm;
    end
  end
endmodule

// File: tb/tb_mult_writeback.sv
// Directed bench for mult_writeback; expected values are hand-computed constants.
module tb_mult_writeback;
  logic clk = 1'b0;
  logic rst_n;
  int   n_chk  = 0;
  int   n_pass = 0;

  always #5 clk = ~clk;

  mult_wb_if bus ();
  mult_writeback dut (.clock(clk), .reset_n(rst_n), .bus(bus.slave));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [63:0] prod, input logic [5:0] dest,
                       input logic [3:0] bmask, input logic [1:0] func);
    bus.in_valid = v;
    bus.in_prod  = prod;
    bus.in_dest  = dest;
    bus.in_bm    = bmask;
    bus.in_func  = func;
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 64'h0, 6'd0, 4'b0, 2'd0);
  endtask

  initial begin
    rst_n            = 1'b0;
    bus.b_mm_resolve = '0;
    bus.b_mm_mispred = 1'b0;
    bus.cdb_grant    = 1'b0;
    idle();
    tick(); tick();
    chk("rst_valid", bus.out_valid, 0);
    chk("rst_occ",   bus.occupancy, 0);
    chk("rst_res",   bus.out_result, 0);
    rst_n = 1'b1;
    tick();
    chk("rst_ready", bus.in_ready, 1);

    // MUL low half, grant held
    bus.cdb_grant = 1'b1;
    drive(1'b1, 64'h0000_0003_FFFF_FFFE, 6'd5, 4'b0, 2'd0);
`ifdef MULT_WB_BYPASS_EN
    chk("mul_byp_valid", bus.out_valid, 1);
    chk("mul_byp_res",   bus.out_result, 64'hFFFF_FFFE);
    tick();
    idle();
`else
    tick();
    idle();
    chk("mul_valid", bus.out_valid, 1);
    chk("mul_res",   bus.out_result, 64'hFFFF_FFFE);
    chk("mul_dest",  bus.out_dest, 5);
    chk("mul_occ1",  bus.occupancy, 1);
    tick();
`endif
    chk("mul_occ0",  bus.occupancy, 0);
    chk("mul_empty_res", bus.out_result, 0);

    // MULH held without grant
    bus.cdb_grant = 1'b0;
    drive(1'b1, 64'h1234_5678_0000_0001, 6'd7, 4'b0, 2'd1);
    tick();
    idle();
    for (int i = 0; i < 3; i++) begin
      chk("mulh_res",   bus.out_result, 64'h1234_5678);
      chk("mulh_occ",   bus.occupancy, 1);
      chk("mulh_valid", bus.out_valid, 1);
      tick();
    end
    bus.cdb_grant = 1'b1;
    tick();
    bus.cdb_grant = 1'b0;
    chk("mulh_drain", bus.occupancy, 0);

    // three back-to-back, full, then grant frees a slot combinationally
    drive(1'b1, 64'h11, 6'd1, 4'b0, 2'd0);
    tick();
    drive(1'b1, 64'h22, 6'd2, 4'b0, 2'd0);
    tick();
    drive(1'b1, 64'h33, 6'd3, 4'b0, 2'd0);
    chk("full_ready0", bus.in_ready, 0);
    tick();
    chk("full_occ", bus.occupancy, 2);
    chk("full_head", bus.out_result, 64'h11);
    bus.cdb_grant = 1'b1;
    #1;
    chk("full_ready1", bus.in_ready, 1);
    tick();
    idle();
    chk("pp_occ",  bus.occupancy, 2);
    chk("ord_2",   bus.out_result, 64'h22);
    tick();
    chk("ord_3",   bus.out_result, 64'h33);
    chk("ord_occ", bus.occupancy, 1);
    tick();
    chk("ord_end", bus.occupancy, 0);
    bus.cdb_grant = 1'b0;

    // squash head, tail survives
    drive(1'b1, 64'hAA, 6'd10, 4'b0010, 2'd0);
    tick();
    drive(1'b1, 64'hBB, 6'd11, 4'b0000, 2'd0);
    tick();
    idle();
    bus.b_mm_resolve = 4'b0010;
    bus.b_mm_mispred = 1'b1;
    #1;
    chk("sq_kill", bus.out_valid, 0);
    tick();
    bus.b_mm_resolve = '0;
    bus.b_mm_mispred = 1'b0;
    #1;
    chk("sq_occ",   bus.occupancy, 1);
    chk("sq_dest",  bus.out_dest, 11);
    chk("sq_res",   bus.out_result, 64'hBB);
    chk("sq_valid", bus.out_valid, 1);
    bus.cdb_grant = 1'b1;
    tick();
    bus.cdb_grant = 1'b0;
    chk("sq_drain", bus.occupancy, 0);

    // correct prediction clears the mask bit only
    drive(1'b1, 64'hAA, 6'd10, 4'b0010, 2'd0);
    tick();
    drive(1'b1, 64'hBB, 6'd11, 4'b0000, 2'd0);
    tick();
    idle();
    chk("res_bm_before", bus.out_bm, 4'b0010);
    bus.b_mm_resolve = 4'b0010;
    #1;
    chk("res_valid", bus.out_valid, 1);
    tick();
    bus.b_mm_resolve = '0;
    #1;
    chk("res_occ",  bus.occupancy, 2);
    chk("res_bm",   bus.out_bm, 4'b0000);
    chk("res_dest", bus.out_dest, 10);

    // reset while full
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("mrst_valid", bus.out_valid, 0);
    chk("mrst_occ",   bus.occupancy, 0);
    chk("mrst_ready", bus.in_ready, 1);
    chk("mrst_dest",  bus.out_dest, 0);

    // incoming packet on a mispredicted path is dropped but accepted
    bus.b_mm_resolve = 4'b0001;
    bus.b_mm_mispred = 1'b1;
    drive(1'b1, 64'h55, 6'd9, 4'b0001, 2'd0);
    chk("drop_ready", bus.in_ready, 1);
    chk("drop_valid", bus.out_valid, 0);
    tick();
    bus.b_mm_resolve = '0;
    bus.b_mm_mispred = 1'b0;
    idle();
    chk("drop_occ", bus.occupancy, 0);

    // push+pop with one entry: new packet becomes head
    drive(1'b1, 64'h20, 6'd20, 4'b0, 2'd0);
    tick();
    bus.cdb_grant = 1'b1;
    drive(1'b1, 64'h21, 6'd21, 4'b0, 2'd0);
    tick();
    bus.cdb_grant = 1'b0;
    idle();
    chk("pp1_occ",  bus.occupancy, 1);
    chk("pp1_dest", bus.out_dest, 21);
    bus.cdb_grant = 1'b1;
    tick();
    bus.cdb_grant = 1'b0;

    // MULHU on empty queue with grant
    bus.cdb_grant = 1'b1;
    drive(1'b1, 64'hFFFF_FFFF_0000_0000, 6'd30, 4'b0, 2'd3);
`ifdef MULT_WB_BYPASS_EN
    chk("mulhu_byp_valid", bus.out_valid, 1);
    chk("mulhu_byp_res",   bus.out_result, 64'hFFFF_FFFF);
    tick();
    idle();
    chk("mulhu_byp_occ", bus.occupancy, 0);
`else
    chk("mulhu_lat_valid", bus.out_valid, 0);
    tick();
    idle();
    chk("mulhu_valid", bus.out_valid, 1);
    chk("mulhu_res",   bus.out_result, 64'hFFFF_FFFF);
    tick();
    chk("mulhu_occ", bus.occupancy, 0);
`endif
    bus.cdb_grant = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/mult_writeback.md
Name: mult_writeback

Overview:
- Drain stage directly downstream of the last multiplier pipeline stage.
- Accepts the finished 64-bit product packet and selects the 32-bit architectural result by func (MUL, MULH, MULHSU, MULHU).
- Buffers results in a 2-entry in-order queue and presents them to the CDB arbiter with a valid/grant handshake.
- Drives the last multiplier stage's next_stage_free, and tracks branch-mask resolve and mispredict squash on every buffered entry.

Parameters:
- DEPTH, 2, queue entries; fixed at 2 for this revision.
- XLEN, 32, result width.
- PROD_W, 64, product width from the multiplier pipeline.
- PREG_W, 6, physical destination register index width.
- BM_W, 4, branch mask width.

Ports:
- clock  in  1  rising-edge clock
- reset_n  in  1  synchronous, active-low reset
- in_valid  in  1  last multiplier stage holds a finished packet
- in_prod  in  PROD_W  accumulated product (prev_sum)
- in_dest  in  PREG_W  destination physical register
- in_bm  in  BM_W  branch mask
- in_func  in  2  0=MUL, 1=MULH, 2=MULHSU, 3=MULHU
- in_ready  out  1  to last multiplier stage's next_stage_free
- b_mm_resolve  in  BM_W  one-hot resolving branch bit, 0 if none
- b_mm_mispred  in  1  the resolving branch mispredicted
- out_valid  out  1  CDB request
- out_result  out  XLEN  result
- out_dest  out  PREG_W  destination register
- out_bm  out  BM_W  current (cleared) mask of the head entry
- cdb_grant  in  1  CDB accepts the head this cycle
- occupancy  out  2  live entries, 0..2

Behaviour:
- Reset (reset_n=0 at posedge):
  - All entries invalid, occupancy=0, out_valid=0.
  - out_result, out_dest, out_bm all 0.
  - in_ready=1 from the first cycle after reset.
  - Reset mid-operation discards all entries; no CDB request in the following cycle.
- Enqueue (in_valid && in_ready at posedge):
  - Store result = in_func==0 ? in_prod[31:0] : in_prod[63:32].
  - Store dest, and bm & ~b_mm_resolve.
  - If b_mm_mispred && |(in_bm & b_mm_resolve), drop the packet: no entry written, but the handshake still completes.
- Latency: 1 cycle from enqueue to out_valid (without the optional feature).
- Per-entry mask update every cycle: bm <= bm & ~b_mm_resolve.
- Squash: if b_mm_mispred and (entry.bm & b_mm_resolve)!=0, the entry is invalidated at the posedge.
- Combinational kill of the head:
  - out_valid = head valid && !(b_mm_mispred && |(head.bm & b_mm_resolve)).
  - A killed head is never granted.
- Dequeue: out_valid && cdb_grant pops the head. cdb_grant while out_valid=0 is ignored.
- in_ready = (occupancy < DEPTH) || (out_valid && cdb_grant).
  - Ready is combinational from grant.
  - Squash does not raise in_ready in the same cycle.
- Next-state ordering, per posedge:
  1. Surviving old entries (not popped, not squashed) keep their relative order, compacted to the head.
  2. The accepted new entry is appended behind them.
  - A squashed head with a surviving tail makes the tail the head next cycle.
- Simultaneous push+pop when full: occupancy stays 2, order preserved.
- Simultaneous push+pop with one entry: the new entry becomes head.
- occupancy never exceeds DEPTH. An in_valid held while in_ready=0 is left untouched upstream (the last stage stalls).
- out_result, out_dest, out_bm reflect the head entry whenever occupancy>0; all 0 when empty.

Optional Feature:
MULT_WB_BYPASS_EN
- Defined:
  - When occupancy==0 and in_valid=1 and the incoming packet is not squashed, outputs present the incoming packet combinationally: out_valid=1, selected result, dest, in_bm & ~b_mm_resolve.
  - If cdb_grant is asserted the same cycle, the packet is consumed with no enqueue (0-cycle latency).
  - Otherwise it is enqueued normally.
- Not defined: outputs come only from the queue; latency is exactly 1 cycle.

Test Plan:
- Reset then MUL, in_prod=64'h0000_0003_FFFF_FFFE, dest=5, grant held 1 -> next cycle out_valid=1, out_result=32'hFFFF_FFFE, out_dest=5, occupancy returns to 0.
- MULH, in_prod=64'h1234_5678_0000_0001, grant=0 for 3 cycles -> out_result=32'h1234_5678 held stable, occupancy=1.
- Three back-to-back packets with grant=0 -> occupancy=2, in_ready=0 on the third. Assert grant -> in_ready=1 the same cycle, third accepted, results leave in order.
- Two entries with bm=4'b0010 (head) and 4'b0000 (tail); b_mm_resolve=4'b0010, mispred=1 -> out_valid=0 that cycle, head dropped, tail becomes head next cycle, occupancy=1.
- Same setup with mispred=0 -> both entries kept, head out_bm=4'b0000 next cycle.
- Reset_n low while occupancy=2 -> next cycle out_valid=0, occupancy=0, in_ready=1.
- With MULT_WB_BYPASS_EN, empty queue, MULHU in_prod=64'hFFFF_FFFF_0000_0000, grant=1 -> out_valid=1 and out_result=32'hFFFF_FFFF the same cycle, occupancy stays 0.
